// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: field widths,
// opcode/funct constants, the alu_op protocol used by the ALU decoder,
// and the main sequencer state enumeration.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;

  // Opcodes (instruction bits [31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // funct field value that turns an R-type into jr
  localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'b001000;

  // alu_op protocol with the ALU decoder
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_ALUWB_R,
    S_IMM_EX,
    S_IMM_WB,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_JAL
  } state_t;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode decode used in DECODE.
// Ports:
//   opcode, funct     : instruction fields from the instruction register
//   next_state_c      : state to enter after DECODE (FETCH when undefined)
//   imm_alu_op_c      : alu_op for immediate ALU instructions
//   illegal_c         : opcode is not a defined instruction
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output state_t             next_state_c,
  output logic [ALUOP_W-1:0] imm_alu_op_c,
  output logic               illegal_c
);

  always_comb begin
    next_state_c = S_FETCH;
    imm_alu_op_c = ALU_ADD;
    illegal_c    = 1'b0;
    case (opcode)
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_SW: next_state_c = S_MEMADR;
      OP_RTYPE: next_state_c = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
      OP_BEQ, OP_BNE:    next_state_c = S_BRANCH;
      OP_ADDI, OP_ADDIU: next_state_c = S_IMM_EX;
      OP_SLTI: begin
        next_state_c = S_IMM_EX;
        imm_alu_op_c = ALU_SLT;
      end
      OP_ANDI: begin
        next_state_c = S_IMM_EX;
        imm_alu_op_c = ALU_AND;
      end
      OP_ORI: begin
        next_state_c = S_IMM_EX;
        imm_alu_op_c = ALU_OR;
      end
      OP_XORI: begin
        next_state_c = S_IMM_EX;
        imm_alu_op_c = ALU_XOR;
      end
      OP_J:    next_state_c = S_JUMP;
      OP_JAL:  next_state_c = S_JAL;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_seq_controller.sv
// Multicycle main sequence controller. Steps FETCH/DECODE/EXECUTE/MEM/WB
// and drives datapath enables, mux selects and the alu_op code for the ALU
// decoder. Memory is variable latency: mem_req is held until mem_ready.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (to FETCH)
//   opcode, funct     : IR fields; funct only distinguishes jr
//   zero              : ALU zero flag, resolves beq/bne
//   mem_ready         : memory completes the current access this cycle
//   mem_req/mem_write/i_or_d : memory request, write qualifier, address select
//   ir_write, pc_en, reg_write : datapath load enables
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src : mux selects
//   alu_op            : operation code for the ALU decoder
//   illegal_op        : single-cycle flag in DECODE on an undefined opcode
// Outputs decode from the state register; only ir_write/pc_en (mem_ready,
// zero) and illegal_op (opcode in DECODE) also look at inputs.
module mips_seq_controller
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_en,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op
);

  state_t             state_q;
  state_t             state_d;
  logic [ALUOP_W-1:0] imm_alu_op_q;
  state_t             dec_next_c;
  logic [ALUOP_W-1:0] dec_alu_op_c;
  logic               dec_illegal_c;

  mips_op_decode u_op_decode (
    .opcode       (opcode),
    .funct        (funct),
    .next_state_c (dec_next_c),
    .imm_alu_op_c (dec_alu_op_c),
    .illegal_c    (dec_illegal_c)
  );

  // State register; immediate alu_op captured while in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      imm_alu_op_q <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) imm_alu_op_q <= dec_alu_op_c;
    end
  end

  // Next state and output decode
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut
        alu_src_b  = 2'b11;
        illegal_op = dec_illegal_c;
        state_d    = dec_next_c;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB_R;
      end
      S_ALUWB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        state_d   = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op_q;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // IR is stable here, so opcode still tells beq from bne
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src  = 2'b11;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_seq_controller.sv
// Randomized bench for mips_seq_controller. A reference model expands each
// instruction into its expected per-cycle control vector trace (including
// memory wait cycles), which is then replayed against the DUT.
module tb_mips_seq_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_en, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       illegal_op;

  mips_seq_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    ctl_t       exp;
  } ent_t;

  typedef enum int {K_LOAD, K_SW, K_R, K_JR, K_BR, K_IMM, K_J, K_JAL, K_ILL} kind_e;

  ctl_t act;
  assign act = ctl_t'({mem_req, mem_write, i_or_d, ir_write, pc_en, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                       alu_op, illegal_op});

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Instruction class straight from the opcode table
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011, 6'b100000, 6'b100100, 6'b100001: return K_LOAD;
      6'b101011: return K_SW;
      6'b000000: return (fn == 6'b001000) ? K_JR : K_R;
      6'b000100, 6'b000101: return K_BR;
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return K_IMM;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_code(input logic [5:0] op);
    case (op)
      6'b001010: return 3'b011;
      6'b001100: return 3'b100;
      6'b001101: return 3'b101;
      6'b001110: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic ctl_t fetch_exp(input logic rdy);
    ctl_t e;
    e = '0;
    e.mem_req   = 1'b1;
    e.alu_src_b = 2'b01;
    e.ir_write  = rdy;
    e.pc_en     = rdy;
    return e;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input ctl_t e);
    ent_t t;
    t.op = op; t.fn = fn; t.z = z; t.mr = mr; t.exp = e;
    q.push_back(t);
  endtask

  // Expand one instruction into its cycle-by-cycle expected trace.
  // wf/wm: wait cycles before mem_ready in fetch / data access.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    ctl_t  e;
    kind_e k;
    k = classify(op, fn);
    for (int i = 0; i <= wf; i++) push(op, fn, z, (i == wf), fetch_exp(i == wf));
    e = '0;
    e.alu_src_b  = 2'b11;
    e.illegal_op = (k == K_ILL);
    push(op, fn, z, 1'($urandom), e);
    case (k)
      K_LOAD, K_SW: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        push(op, fn, z, 1'($urandom), e);
        for (int i = 0; i <= wm; i++) begin
          e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_write = (k == K_SW);
          push(op, fn, z, (i == wm), e);
        end
        if (k == K_LOAD) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          push(op, fn, z, 1'($urandom), e);
        end
      end
      K_R: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
        push(op, fn, z, 1'($urandom), e);
        e = '0; e.reg_write = 1'b1; e.reg_dst = 2'b01;
        push(op, fn, z, 1'($urandom), e);
      end
      K_JR: begin
        e = '0; e.pc_src = 2'b11; e.pc_en = 1'b1;
        push(op, fn, z, 1'($urandom), e);
      end
      K_BR: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01;
        e.pc_en = (op == 6'b000100) ? z : !z;
        push(op, fn, z, 1'($urandom), e);
      end
      K_IMM: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = imm_code(op);
        push(op, fn, z, 1'($urandom), e);
        e = '0; e.reg_write = 1'b1;
        push(op, fn, z, 1'($urandom), e);
      end
      K_J: begin
        e = '0; e.pc_src = 2'b10; e.pc_en = 1'b1;
        push(op, fn, z, 1'($urandom), e);
      end
      K_JAL: begin
        e = '0; e.pc_src = 2'b10; e.pc_en = 1'b1; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        push(op, fn, z, 1'($urandom), e);
      end
      default: ;
    endcase
  endtask

  // Replay up to 'limit' queued cycles: drive at negedge, compare 1ns later
  task automatic run_q(input int limit);
    ent_t t;
    int   n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      t = q.pop_front();
      @(negedge clk);
      opcode    = t.op;
      funct     = t.fn;
      zero      = t.z;
      mem_ready = t.mr;
      #1;
      check($sformatf("cyc%0d_op%b", cyc, t.op), 32'(act), 32'(t.exp));
      cyc++;
      n++;
    end
  endtask

  logic [5:0] legal [16] = '{6'b100011, 6'b100000, 6'b100100, 6'b100001,
                             6'b101011, 6'b000000, 6'b000100, 6'b000101,
                             6'b001000, 6'b001001, 6'b001010, 6'b001100,
                             6'b001101, 6'b001110, 6'b000010, 6'b000011};

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    check("reset_state", 32'(act), 32'(fetch_exp(1'b0)));
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset asserted while waiting in MEMRD of a lw
    gen_instr(6'b100011, 6'b000000, 1'b0, 0, 5);
    run_q(4);
    check("memrd_before_rst", 32'({mem_req, i_or_d}), 32'(2'b11));
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(act), 32'(fetch_exp(1'b0)));
    q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); mem_ready = 1'b1;
    #1 check("fetch_after_rst", 32'(act), 32'(fetch_exp(1'b1)));
    @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed instructions from the test plan, then the rest of the ISA
    gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0); // add
    gen_instr(6'b100011, 6'b000000, 1'b0, 0, 3); // lw, 3 waits
    gen_instr(6'b000100, 6'b000000, 1'b1, 0, 0); // beq taken
    gen_instr(6'b000101, 6'b000000, 1'b1, 0, 0); // bne not taken
    gen_instr(6'b001101, 6'b000000, 1'b0, 0, 0); // ori
    gen_instr(6'b001010, 6'b000000, 1'b0, 0, 0); // slti
    gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0); // illegal
    gen_instr(6'b000011, 6'b000000, 1'b0, 0, 0); // jal
    gen_instr(6'b101011, 6'b000000, 1'b0, 1, 2); // sw
    gen_instr(6'b000000, 6'b001000, 1'b0, 0, 0); // jr
    gen_instr(6'b000010, 6'b000000, 1'b0, 2, 0); // j
    gen_instr(6'b001110, 6'b000000, 1'b0, 0, 0); // xori
    gen_instr(6'b001100, 6'b000000, 1'b0, 0, 0); // andi
    run_q(1000);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
      fn = (op == 6'b000000 && $urandom_range(0, 1) == 1) ? 6'b001000 : 6'($urandom);
      gen_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      run_q(1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
